// File: rtl/ball_pkg.sv
// Shared types, defaults and helpers for the ball engine.
package ball_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVING = 2'd1,
        OUT    = 2'd2
    } state_e;

    localparam int unsigned SCREEN_W_DEF = 640;
    localparam int unsigned SCREEN_H_DEF = 480;

    // Sign-extend the low w bits of v to 32 bits.
    function automatic logic signed [31:0] sext(input logic [31:0] v, input int unsigned w);
        logic signed [31:0] t;
        t = signed'(v << (32 - w));
        return t >>> (32 - w);
    endfunction

endpackage

// File: rtl/ball_sprite_mask.sv
// Combinational sprite coverage test: half-open rectangle with optional corner trim.
module ball_sprite_mask
    import ball_pkg::*;
#(
    parameter int unsigned XW    = 10,
    parameter int unsigned YW    = 10,
    parameter int unsigned SW    = 5,
    parameter int unsigned ROUND = 1
) (
    input  logic [XW-1:0] xpix_i,
    input  logic [YW-1:0] ypix_i,
    input  logic [XW-1:0] x_i,
    input  logic [YW-1:0] y_i,
    input  logic [SW-1:0] w_i,
    input  logic [SW-1:0] h_i,
    output logic          inside_c_o
);

    localparam int unsigned XP = XW + 1;
    localparam int unsigned YP = YW + 1;
    localparam int unsigned CW = ((XW > YW) ? XW : YW) + 2;

    logic [XP-1:0] x_end, dx_lo, dx_hi;
    logic [YP-1:0] y_end, dy_lo, dy_hi;
    logic [CW-1:0] lx, ly, k;
    logic [SW-1:0] wh_min;
    logic          in_rect, trim;

    // Rectangle test at one extra bit so x+w never wraps; corner trim by taxicab distance.
    always_comb begin
        x_end   = XP'(x_i) + XP'(w_i);
        y_end   = YP'(y_i) + YP'(h_i);
        in_rect = (w_i != '0) && (h_i != '0)
                  && (XP'(xpix_i) >= XP'(x_i)) && (XP'(xpix_i) < x_end)
                  && (YP'(ypix_i) >= YP'(y_i)) && (YP'(ypix_i) < y_end);
        dx_lo   = XP'(xpix_i) - XP'(x_i);
        dx_hi   = x_end - XP'(1) - XP'(xpix_i);
        dy_lo   = YP'(ypix_i) - YP'(y_i);
        dy_hi   = y_end - YP'(1) - YP'(ypix_i);
        lx      = CW'((dx_lo < dx_hi) ? dx_lo : dx_hi);
        ly      = CW'((dy_lo < dy_hi) ? dy_lo : dy_hi);
        wh_min  = (w_i < h_i) ? w_i : h_i;
        k       = CW'(wh_min >> 2);
        trim    = (ROUND != 0) && ((lx + ly) < k);
        inside_c_o = in_rect && !trim;
    end

endmodule

// File: rtl/ball_engine.sv
// Ball position/velocity engine with per-frame motion, wall bounce, exit detection and sprite pixel.
module ball_engine
    import ball_pkg::*;
#(
    parameter int unsigned XW       = 10,
    parameter int unsigned YW       = 10,
    parameter int unsigned SW       = 5,
    parameter int unsigned VW       = 4,
    parameter int unsigned SCREEN_W = SCREEN_W_DEF,
    parameter int unsigned SCREEN_H = SCREEN_H_DEF,
    parameter int unsigned ROUND    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_tick,
    input  logic          serve,
    input  logic          freeze,
    input  logic          paddle_hit,
    input  logic [XW-1:0] x_start,
    input  logic [YW-1:0] y_start,
    input  logic [VW-1:0] vx_in,
    input  logic [VW-1:0] vy_in,
    input  logic [SW-1:0] width_ball,
    input  logic [SW-1:0] height_ball,
    input  logic [XW-1:0] xpix,
    input  logic [YW-1:0] ypix,
    output logic [XW-1:0] x_ball,
    output logic [YW-1:0] y_ball,
    output logic          moving,
    output logic          wall_hit,
    output logic          exit_left,
    output logic          exit_right,
    output logic          pixvalball
);

    localparam int unsigned XA = XW + 2;
    localparam int unsigned YA = YW + 2;

    state_e        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [VW-1:0] vx_q, vx_d, vy_q, vy_d, vx_eff;
    logic          flip_q, flip_d, moving_q, moving_d, pix_q, pix_d;
    logic          wall_q, wall_d, exl_q, exl_d, exr_q, exr_d;
    logic          upd_c, top_c, bot_c, exl_c, exr_c, inside_c;
    logic signed [XA-1:0] nx_s, w_s, sw_s;
    logic signed [YA-1:0] ny_s, h_s, sh_s;

    ball_sprite_mask #(
        .XW(XW), .YW(YW), .SW(SW), .ROUND(ROUND)
    ) u_mask (
        .xpix_i    (xpix),
        .ypix_i    (ypix),
        .x_i       (x_q),
        .y_i       (y_q),
        .w_i       (width_ball),
        .h_i       (height_ball),
        .inside_c_o(inside_c)
    );

    // Candidate next position and wall/exit classification for this frame.
    always_comb begin
        upd_c  = frame_tick && !freeze && (state_q == MOVING) && !serve;
        vx_eff = (flip_q || paddle_hit) ? (~vx_q + VW'(1)) : vx_q;
        w_s    = XA'(width_ball);
        h_s    = YA'(height_ball);
        sw_s   = XA'(SCREEN_W);
        sh_s   = YA'(SCREEN_H);
        nx_s   = XA'(x_q) + XA'(sext(32'(vx_eff), VW));
        ny_s   = YA'(y_q) + YA'(sext(32'(vy_q), VW));
        top_c  = ny_s[YA-1];
        bot_c  = !top_c && ((ny_s + h_s) > sh_s);
        exl_c  = nx_s[XA-1];
        exr_c  = !exl_c && ((nx_s + w_s) > sw_s);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: serve always wins, an exit during an update parks the ball.
    always_comb begin
        state_d = state_q;
        if (serve)                      state_d = MOVING;
        else if (upd_c && (exl_c || exr_c)) state_d = OUT;
    end

    // Next values for position, velocity, pending flip, pulses and pixel.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        vx_d   = vx_q;
        vy_d   = vy_q;
        flip_d = flip_q || paddle_hit;
        wall_d = 1'b0;
        exl_d  = 1'b0;
        exr_d  = 1'b0;
        if (serve) begin
            x_d    = x_start;
            y_d    = y_start;
            vx_d   = vx_in;
            vy_d   = vy_in;
            flip_d = 1'b0;
        end else if (upd_c) begin
            vx_d   = vx_eff;
            flip_d = 1'b0;
            if (top_c) begin
                y_d    = YW'(-ny_s);
                vy_d   = ~vy_q + VW'(1);
                wall_d = 1'b1;
            end else if (bot_c) begin
                y_d    = YW'((sh_s - h_s) + (sh_s - h_s) - ny_s);
                vy_d   = ~vy_q + VW'(1);
                wall_d = 1'b1;
            end else begin
                y_d = YW'(ny_s);
            end
            if (exl_c) begin
                x_d   = '0;
                exl_d = 1'b1;
            end else if (exr_c) begin
                x_d   = XW'(sw_s - w_s);
                exr_d = 1'b1;
            end else begin
                x_d = XW'(nx_s);
            end
        end
        moving_d = (state_d == MOVING);
        pix_d    = inside_c && (state_q != OUT);
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q      <= XW'(SCREEN_W / 2);
            y_q      <= YW'(SCREEN_H / 2);
            vx_q     <= '0;
            vy_q     <= '0;
            flip_q   <= 1'b0;
            moving_q <= 1'b0;
            wall_q   <= 1'b0;
            exl_q    <= 1'b0;
            exr_q    <= 1'b0;
            pix_q    <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            vx_q     <= vx_d;
            vy_q     <= vy_d;
            flip_q   <= flip_d;
            moving_q <= moving_d;
            wall_q   <= wall_d;
            exl_q    <= exl_d;
            exr_q    <= exr_d;
            pix_q    <= pix_d;
        end
    end

    assign x_ball     = x_q;
    assign y_ball     = y_q;
    assign moving     = moving_q;
    assign wall_hit   = wall_q;
    assign exit_left  = exl_q;
    assign exit_right = exr_q;
    assign pixvalball = pix_q;

endmodule

// File: tb/tb_ball_engine.sv
// Bench for ball_engine: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a behavioural model.
module tb_ball_engine;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0, serve = 1'b0, freeze = 1'b0, paddle_hit = 1'b0;
    logic [9:0] x_start = '0, y_start = '0, xpix = '0, ypix = '0;
    logic [3:0] vx_in = '0, vy_in = '0;
    logic [4:0] width_ball = 5'd8, height_ball = 5'd8;

    logic [9:0] x_ball, y_ball, x_ball0, y_ball0;
    logic       moving, wall_hit, exit_left, exit_right, pix1;
    logic       moving0, wall_hit0, exit_left0, exit_right0, pix0;

    int total = 0;
    int bad   = 0;

    // Behavioural model state: st 0=idle 1=moving 2=out
    int mx, my, mvx, mvy, mst;
    bit mflip, e_wall, e_exl, e_exr, e_pix1, e_pix0;

    always #5 clk = ~clk;

    ball_engine dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .serve(serve), .freeze(freeze),
        .paddle_hit(paddle_hit), .x_start(x_start), .y_start(y_start), .vx_in(vx_in),
        .vy_in(vy_in), .width_ball(width_ball), .height_ball(height_ball), .xpix(xpix),
        .ypix(ypix), .x_ball(x_ball), .y_ball(y_ball), .moving(moving), .wall_hit(wall_hit),
        .exit_left(exit_left), .exit_right(exit_right), .pixvalball(pix1)
    );

    ball_engine #(.ROUND(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .serve(serve), .freeze(freeze),
        .paddle_hit(paddle_hit), .x_start(x_start), .y_start(y_start), .vx_in(vx_in),
        .vy_in(vy_in), .width_ball(width_ball), .height_ball(height_ball), .xpix(xpix),
        .ypix(ypix), .x_ball(x_ball0), .y_ball(y_ball0), .moving(moving0), .wall_hit(wall_hit0),
        .exit_left(exit_left0), .exit_right(exit_right0), .pixvalball(pix0)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int s4(input logic [3:0] v);
        return v[3] ? int'(v) - 16 : int'(v);
    endfunction

    function automatic bit sprite_in(input int xp, input int yp, input int x, input int y,
                                     input int w, input int h, input bit rnd);
        int lx, ly, k;
        if (w == 0 || h == 0) return 1'b0;
        if (xp < x || xp >= x + w || yp < y || yp >= y + h) return 1'b0;
        if (!rnd) return 1'b1;
        lx = (xp - x < x + w - 1 - xp) ? xp - x : x + w - 1 - xp;
        ly = (yp - y < y + h - 1 - yp) ? yp - y : y + h - 1 - yp;
        k  = ((w < h) ? w : h) / 4;
        return (lx + ly) >= k;
    endfunction

    task automatic model_reset();
        mx = 320; my = 240; mvx = 0; mvy = 0; mst = 0; mflip = 1'b0;
        e_wall = 1'b0; e_exl = 1'b0; e_exr = 1'b0; e_pix1 = 1'b0; e_pix0 = 1'b0;
    endtask

    task automatic model_step();
        int nx, ny, w, h;
        w = int'(width_ball);
        h = int'(height_ball);
        e_pix1 = sprite_in(int'(xpix), int'(ypix), mx, my, w, h, 1'b1) && (mst != 2);
        e_pix0 = sprite_in(int'(xpix), int'(ypix), mx, my, w, h, 1'b0) && (mst != 2);
        e_wall = 1'b0; e_exl = 1'b0; e_exr = 1'b0;
        if (serve) begin
            mx = int'(x_start); my = int'(y_start);
            mvx = s4(vx_in); mvy = s4(vy_in);
            mflip = 1'b0; mst = 1;
        end else if (frame_tick && !freeze && mst == 1) begin
            if (mflip || paddle_hit) mvx = -mvx;
            mflip = 1'b0;
            ny = my + mvy;
            if (ny < 0) begin
                my = -ny; mvy = -mvy; e_wall = 1'b1;
            end else if (ny + h > 480) begin
                my = 2 * (480 - h) - ny; mvy = -mvy; e_wall = 1'b1;
            end else begin
                my = ny;
            end
            nx = mx + mvx;
            if (nx < 0) begin
                mx = 0; e_exl = 1'b1; mst = 2;
            end else if (nx + w > 640) begin
                mx = 640 - w; e_exr = 1'b1; mst = 2;
            end else begin
                mx = nx;
            end
        end else if (paddle_hit) begin
            mflip = 1'b1;
        end
    endtask

    task automatic model_check();
        chk("x_ball", int'(x_ball), mx);
        chk("y_ball", int'(y_ball), my);
        chk("moving", int'(moving), int'(mst == 1));
        chk("wall_hit", int'(wall_hit), int'(e_wall));
        chk("exit_left", int'(exit_left), int'(e_exl));
        chk("exit_right", int'(exit_right), int'(e_exr));
        chk("pix_round", int'(pix1), int'(e_pix1));
        chk("pix_rect", int'(pix0), int'(e_pix0));
    endtask

    // Model tracks every clock edge / async reset and is compared 1 time unit later.
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
            #1;
            model_check();
        end
    end

    task automatic do_serve(input int x, input int y, input int vx, input int vy);
        serve = 1'b1; x_start = 10'(x); y_start = 10'(y); vx_in = 4'(vx); vy_in = 4'(vy);
        @(negedge clk);
        serve = 1'b0;
    endtask

    task automatic do_tick();
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic pix_at(input int x, input int y);
        xpix = 10'(x); ypix = 10'(y);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_x", int'(x_ball), 320);
        chk("rst_y", int'(y_ball), 240);
        chk("rst_moving", int'(moving), 0);
        chk("rst_pix", int'(pix1), 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_serve(100, 100, 3, -2);
        chk("serve_moving", int'(moving), 1);
        do_tick();
        do_tick();
        chk("move_x", int'(x_ball), 106);
        chk("move_y", int'(y_ball), 96);
        chk("move_nowall", int'(wall_hit), 0);

        do_serve(50, 1, 0, -3);
        do_tick();
        chk("top_y", int'(y_ball), 2);
        chk("top_wall", int'(wall_hit), 1);
        @(negedge clk);
        chk("top_wall_end", int'(wall_hit), 0);
        do_tick();
        chk("top_vy_flipped", int'(y_ball), 5);

        do_serve(50, 470, 0, 4);
        do_tick();
        chk("bot_y", int'(y_ball), 470);
        chk("bot_wall", int'(wall_hit), 1);

        do_serve(2, 100, -4, 0);
        do_tick();
        chk("exl_pulse", int'(exit_left), 1);
        chk("exl_x", int'(x_ball), 0);
        chk("exl_moving", int'(moving), 0);
        @(negedge clk);
        chk("exl_pulse_end", int'(exit_left), 0);
        for (int dy = 0; dy < 8; dy++)
            for (int dx = 0; dx < 8; dx++) begin
                pix_at(dx, 100 + dy);
                chk("out_hidden", int'(pix1), 0);
            end
        do_serve(2, 100, -4, 0);
        chk("reserve_moving", int'(moving), 1);

        paddle_hit = 1'b1; @(negedge clk); paddle_hit = 1'b0;
        do_tick();
        chk("rescue_x", int'(x_ball), 6);
        chk("rescue_noexit", int'(exit_left), 0);

        do_serve(2, 100, -4, 0);
        paddle_hit = 1'b1; @(negedge clk); @(negedge clk); paddle_hit = 1'b0;
        do_tick();
        chk("dblhit_x", int'(x_ball), 6);
        chk("dblhit_moving", int'(moving), 1);

        do_serve(200, 150, 0, 0);
        pix_at(200, 150); chk("corner_00", int'(pix1), 0);
        pix_at(201, 150); chk("corner_10", int'(pix1), 0);
        pix_at(202, 150); chk("edge_20", int'(pix1), 1);
        pix_at(203, 153); chk("centre", int'(pix1), 1);
        pix_at(207, 157); chk("corner_77", int'(pix1), 0);
        pix_at(199, 150); chk("left_of", int'(pix1), 0);
        pix_at(208, 150); chk("right_of", int'(pix1), 0);
        for (int dy = 0; dy < 8; dy++)
            for (int dx = 0; dx < 8; dx++) begin
                pix_at(200 + dx, 150 + dy);
                chk("rect_full", int'(pix0), 1);
            end

        do_serve(300, 200, 5, 5);
        do_tick();
        chk("pre_x", int'(x_ball), 305);
        serve = 1'b1; frame_tick = 1'b1; x_start = 10'd10; y_start = 10'd20;
        vx_in = 4'd1; vy_in = 4'd1;
        @(negedge clk);
        serve = 1'b0; frame_tick = 1'b0;
        chk("serve_wins_x", int'(x_ball), 10);
        chk("serve_wins_y", int'(y_ball), 20);

        freeze = 1'b1;
        repeat (3) do_tick();
        chk("freeze_x", int'(x_ball), 10);
        chk("freeze_y", int'(y_ball), 20);
        freeze = 1'b0;
        do_tick();
        chk("thaw_x", int'(x_ball), 11);

        #2 rst_n = 1'b0;
        #1;
        chk("async_x", int'(x_ball), 320);
        chk("async_y", int'(y_ball), 240);
        chk("async_moving", int'(moving), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 799) != 0);
            serve = ($urandom_range(0, 39) == 0);
            if (serve) begin
                width_ball  = ($urandom_range(0, 15) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                height_ball = ($urandom_range(0, 15) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                x_start = 10'($urandom_range(0, 640 - int'(width_ball)));
                y_start = 10'($urandom_range(0, 480 - int'(height_ball)));
                vx_in   = 4'(int'($urandom_range(0, 14)) - 7);
                vy_in   = 4'(int'($urandom_range(0, 14)) - 7);
            end
            frame_tick = ($urandom_range(0, 3) == 0);
            paddle_hit = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 49) == 0) freeze = ~freeze;
            xpix = 10'(mx + int'($urandom_range(0, 40)) - 5);
            ypix = 10'(my + int'($urandom_range(0, 40)) - 5);
        end
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
